mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one slow off-chip memory port between the I-cache and D-cache miss/writeback paths.
//  Sits between both cache memory-side interfaces and a single memory.
//  Grants one 128-bit line transaction at a time and holds it until mem_ready.
//  Routes ready and read data back to the granted cache only.
// PARAMETERS
//  ADDR_W  28   line address width (byte address bits [31:4])
//  DATA_W  128  line width in bits
// PORTS
//  clk          in   1       clock, all state on rising edge
//  proc_reset   in   1       asynchronous, active-high reset
//  mem_read_I   in   1       I-cache line read request, held until mem_ready_I
//  mem_write_I  in   1       I-cache line write request, held until mem_ready_I
//  mem_addr_I   in   ADDR_W  I-cache line address
//  mem_wdata_I  in   DATA_W  I-cache write line
//  mem_rdata_I  out  DATA_W  read line to I-cache
//  mem_ready_I  out  1       completion pulse to I-cache
//  mem_read_D / mem_write_D / mem_addr_D / mem_wdata_D / mem_rdata_D / mem_ready_D: same for D-cache
//  mem_read     out  1       to memory, registered
//  mem_write    out  1       to memory, registered
//  mem_addr     out  ADDR_W  to memory, registered
//  mem_wdata    out  DATA_W  to memory, registered
//  mem_rdata    in   DATA_W  from memory
//  mem_ready    in   1       memory completion, one cycle high
//  arb_owner    out  2       00 none, 01 I, 10 D (debug/status)
// BEHAVIOUR
//  FSM states: IDLE, BUSY_I, BUSY_D, RELEASE.
//  Reset: state IDLE; mem_read/mem_write/arb_owner 0; mem_addr/mem_wdata 0; ready outputs 0. Reset asserted mid-transaction abandons it, no ready issued.
//  IDLE: sample requests (read|write per client). Selection: D over I. On edge, latch addr/wdata/op of winner into mem_* regs, go BUSY_x; memory sees request 1 cycle after client raised it.
//  Both read and write from one client: treated as write; read dropped (illegal, assertion).
//  BUSY_x: mem_* held stable, ignore other client. mem_ready_x = mem_ready (combinational), mem_rdata_x = mem_rdata. Non-granted ready always 0; rdata to both may be mem_rdata (ready qualifies).
//  On mem_ready in BUSY_x: next edge clears mem_read/mem_write, go RELEASE.
//  RELEASE: one cycle, no grant; lets finished client drop request so it is not re-issued. Then IDLE.
//  Client-to-client switch costs: ready cycle + RELEASE + IDLE = new request visible to memory 3 cycles after previous mem_ready.
//  Client deasserting request while BUSY: ignored; transaction completes to memory, ready pulse still sent.
//  mem_ready in IDLE/RELEASE: ignored.
//  arb_owner = 01/10 in BUSY_I/BUSY_D, else 00.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; 1-bit last_owner reg (reset = I) and when both request in IDLE, the client not last served wins.
//  Not defined: fixed D priority as above; no last_owner reg.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D, RELEASE), owner codes, ADDR_W/DATA_W defaults.
//  Sub-module mem_arb_pick: combinational winner select (req_I, req_D, last_owner) -> grant_I, grant_D; holds the MEM_ARB_RR_EN difference.
// TESTING
//  D read only, addr 28'h0000010, memory ready after 8 cycles -> mem_read high cycle 1..8, mem_ready_D pulse, mem_ready_I never high, rdata_D matches.
//  I and D read same cycle -> D served first, I read on memory 3 cycles after D's ready; I data 128'hA5.. correct.
//  MEM_ARB_RR_EN: I and D request continuously for 4 transactions -> order D,I,D,I; without macro -> D,D,D,D while D holds.
//  D write addr 28'h0000020 data 128'h1234.. -> mem_write, mem_addr, mem_wdata stable until ready; no write re-issued after RELEASE.
//  proc_reset high during BUSY_I at cycle 3 -> all outputs 0 same cycle, state IDLE, no mem_ready_I pulse.
//  Spurious mem_ready in IDLE -> no ready to either client, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } arbState_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_I    = 2'b01;
    localparam logic [1:0] OWNER_D    = 2'b10;

    // Encoding of the client served most recently (round-robin build only).
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between I-cache and D-cache requests.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic reqI_i,
    input  logic reqD_i,
`ifdef MEM_ARB_RR_EN
    input  logic lastOwner_i,
`endif
    output logic grantI_o,
    output logic grantD_o
);

    always_comb begin
        grantI_o = 1'b0;
        grantD_o = 1'b0;
`ifdef MEM_ARB_RR_EN
        // On contention the client that was not served last goes first.
        if (reqI_i && reqD_i) begin
            grantI_o = (lastOwner_i == LAST_D);
            grantD_o = (lastOwner_i == LAST_I);
        end else begin
            grantI_o = reqI_i;
            grantD_o = reqD_i;
        end
`else
        grantD_o = reqD_i;
        grantI_o = reqI_i & ~reqD_i;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache and D-cache, one line transaction at a time.
// Optional round-robin arbitration via MEM_ARB_RR_EN (default: fixed D priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [ADDR_W-1:0] mem_addr_I,
    input  logic [DATA_W-1:0] mem_wdata_I,
    output logic [DATA_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,
    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [ADDR_W-1:0] mem_addr_D,
    input  logic [DATA_W-1:0] mem_wdata_D,
    output logic [DATA_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        arb_owner
);

    arbState_e         state_q, state_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              reqI, reqD, grantI, grantD;

    assign reqI = mem_read_I | mem_write_I;
    assign reqD = mem_read_D | mem_write_D;

`ifdef MEM_ARB_RR_EN
    logic lastOwner_q, lastOwner_d;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) lastOwner_q <= LAST_I;
        else            lastOwner_q <= lastOwner_d;
    end
`endif

    mem_arb_pick uPick (
        .reqI_i      (reqI),
        .reqD_i      (reqD),
`ifdef MEM_ARB_RR_EN
        .lastOwner_i (lastOwner_q),
`endif
        .grantI_o    (grantI),
        .grantD_o    (grantD)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    // A read+write request from one client is issued as a write only.
    always_comb begin
        state_d    = state_q;
        memRead_d  = memRead_q;
        memWrite_d = memWrite_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
`ifdef MEM_ARB_RR_EN
        lastOwner_d = lastOwner_q;
`endif
        case (state_q)
            IDLE: begin
                if (grantD) begin
                    state_d    = BUSY_D;
                    memWrite_d = mem_write_D;
                    memRead_d  = mem_read_D & ~mem_write_D;
                    memAddr_d  = mem_addr_D;
                    memWdata_d = mem_wdata_D;
`ifdef MEM_ARB_RR_EN
                    lastOwner_d = LAST_D;
`endif
                end else if (grantI) begin
                    state_d    = BUSY_I;
                    memWrite_d = mem_write_I;
                    memRead_d  = mem_read_I & ~mem_write_I;
                    memAddr_d  = mem_addr_I;
                    memWdata_d = mem_wdata_I;
`ifdef MEM_ARB_RR_EN
                    lastOwner_d = LAST_I;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d    = RELEASE;
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_read    = memRead_q;
    assign mem_write   = memWrite_q;
    assign mem_addr    = memAddr_q;
    assign mem_wdata   = memWdata_q;
    assign mem_ready_I = (state_q == BUSY_I) & mem_ready;
    assign mem_ready_D = (state_q == BUSY_D) & mem_ready;
    assign mem_rdata_I = mem_rdata;
    assign mem_rdata_D = mem_rdata;

    always_comb begin
        arb_owner = OWNER_NONE;
        case (state_q)
            BUSY_I:  arb_owner = OWNER_I;
            BUSY_D:  arb_owner = OWNER_D;
            default: arb_owner = OWNER_NONE;
        endcase
    end

    assert property (@(posedge clk) disable iff (proc_reset) !(mem_read_I && mem_write_I));
    assert property (@(posedge clk) disable iff (proc_reset) !(mem_read_D && mem_write_D));

endmodule
